// File: rtl/lc3_execute.sv
// lc3_execute: LC3 execute stage with ALU, address adder, operand bypass and registered outputs
module lc3_execute (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_execute,
    input  logic [5:0]  E_Control,
    input  logic [15:0] IR,
    input  logic [15:0] npc_in,
    input  logic [1:0]  W_Control_in,
    input  logic        Mem_Control_in,
    input  logic [15:0] VSR1,
    input  logic [15:0] VSR2,
    input  logic        bypass_alu_1,
    input  logic        bypass_alu_2,
    input  logic        bypass_mem_1,
    input  logic        bypass_mem_2,
    input  logic [15:0] Mem_Bypass_Val,
    output logic [15:0] aluout,
    output logic [15:0] pcout,
    output logic [2:0]  NZP,
    output logic [2:0]  dr,
    output logic [15:0] M_Data,
    output logic [15:0] IR_Exec,
    output logic [1:0]  W_Control_out,
    output logic        Mem_Control_out,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2
);
    logic [15:0] aluout_q, aluout_d, pcout_q, pcout_d, m_data_q, m_data_d, ir_exec_q, ir_exec_d;
    logic [2:0]  nzp_q, nzp_d, dr_q, dr_d;
    logic [1:0]  w_control_q, w_control_d;
    logic        mem_control_q, mem_control_d;
    logic [3:0]  opcode;
    logic [15:0] op1, rs2, op2, alu_res, offset, base, addr;
    logic        is_store, is_alu;

    assign opcode   = IR[15:12];
    assign is_store = opcode inside {4'b0011, 4'b0111, 4'b1011};
    assign is_alu   = opcode inside {4'b0001, 4'b0101, 4'b1001};
    assign sr1      = IR[8:6];
    assign sr2      = is_store ? IR[11:9] : IR[2:0];

    // Operand selection, ALU and address adder; ALU bypass sees the pre-edge aluout
    always_comb begin
        op1     = bypass_alu_1 ? aluout_q : bypass_mem_1 ? Mem_Bypass_Val : VSR1;
        rs2     = bypass_alu_2 ? aluout_q : bypass_mem_2 ? Mem_Bypass_Val : VSR2;
        op2     = E_Control[0] ? rs2 : {{11{IR[4]}}, IR[4:0]};
        alu_res = E_Control[5:4] == 2'b00 ? op1 + op2 :
                  E_Control[5:4] == 2'b01 ? op1 & op2 :
                  E_Control[5:4] == 2'b10 ? ~op1 : 16'h0000;
        offset  = E_Control[3:2] == 2'b00 ? {{5{IR[10]}}, IR[10:0]} :
                  E_Control[3:2] == 2'b01 ? {{7{IR[8]}}, IR[8:0]} :
                  E_Control[3:2] == 2'b10 ? {{10{IR[5]}}, IR[5:0]} : 16'h0000;
        base    = E_Control[1] ? npc_in : op1;
        addr    = base + offset;
    end

    // Next-state values: capture when enabled, otherwise hold
    always_comb begin
        aluout_d      = enable_execute ? (is_alu ? alu_res : addr) : aluout_q;
        pcout_d       = enable_execute ? addr : pcout_q;
        nzp_d         = enable_execute ? (opcode == 4'b0000 ? IR[11:9] :
                                          opcode == 4'b1100 ? 3'b111 : 3'b000) : nzp_q;
        dr_d          = enable_execute ? IR[11:9] : dr_q;
        m_data_d      = enable_execute ? rs2 : m_data_q;
        ir_exec_d     = enable_execute ? IR : ir_exec_q;
        w_control_d   = enable_execute ? W_Control_in : w_control_q;
        mem_control_d = enable_execute ? Mem_Control_in : mem_control_q;
    end

    // Pipeline registers, cleared asynchronously by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aluout_q      <= '0;
            pcout_q       <= '0;
            nzp_q         <= '0;
            dr_q          <= '0;
            m_data_q      <= '0;
            ir_exec_q     <= '0;
            w_control_q   <= '0;
            mem_control_q <= 1'b0;
        end else begin
            aluout_q      <= aluout_d;
            pcout_q       <= pcout_d;
            nzp_q         <= nzp_d;
            dr_q          <= dr_d;
            m_data_q      <= m_data_d;
            ir_exec_q     <= ir_exec_d;
            w_control_q   <= w_control_d;
            mem_control_q <= mem_control_d;
        end
    end

    assign aluout          = aluout_q;
    assign pcout           = pcout_q;
    assign NZP             = nzp_q;
    assign dr              = dr_q;
    assign M_Data          = m_data_q;
    assign IR_Exec         = ir_exec_q;
    assign W_Control_out   = w_control_q;
    assign Mem_Control_out = mem_control_q;
endmodule

// File: tb/tb_lc3_execute.sv
// tb_lc3_execute: directed scoreboard bench for the LC3 execute stage
module tb_lc3_execute;
    logic        clock, reset, enable_execute;
    logic [5:0]  E_Control;
    logic [15:0] IR, npc_in, VSR1, VSR2, Mem_Bypass_Val;
    logic [1:0]  W_Control_in;
    logic        Mem_Control_in;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [15:0] aluout, pcout, M_Data, IR_Exec;
    logic [2:0]  NZP, dr, sr1, sr2;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;

    typedef struct {
        logic [15:0] alu, pc, md, ir;
        logic [2:0]  nzp, dr;
        logic [1:0]  wc;
        logic        mc;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   errors = 0;
    int   checks = 0;

    lc3_execute dut (
        .clock(clock), .reset(reset), .enable_execute(enable_execute),
        .E_Control(E_Control), .IR(IR), .npc_in(npc_in),
        .W_Control_in(W_Control_in), .Mem_Control_in(Mem_Control_in),
        .VSR1(VSR1), .VSR2(VSR2),
        .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
        .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
        .Mem_Bypass_Val(Mem_Bypass_Val),
        .aluout(aluout), .pcout(pcout), .NZP(NZP), .dr(dr), .M_Data(M_Data),
        .IR_Exec(IR_Exec), .W_Control_out(W_Control_out),
        .Mem_Control_out(Mem_Control_out), .sr1(sr1), .sr2(sr2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".aluout"}, aluout, e.alu);
        chk({tag, ".pcout"}, pcout, e.pc);
        chk({tag, ".nzp"}, {13'b0, NZP}, {13'b0, e.nzp});
        chk({tag, ".dr"}, {13'b0, dr}, {13'b0, e.dr});
        chk({tag, ".mdata"}, M_Data, e.md);
        chk({tag, ".ir_exec"}, IR_Exec, e.ir);
        chk({tag, ".wctl"}, {14'b0, W_Control_out}, {14'b0, e.wc});
        chk({tag, ".mctl"}, {15'b0, Mem_Control_out}, {15'b0, e.mc});
    endtask

    task automatic drive(input logic [15:0] ir, input logic [5:0] ec, input logic [15:0] npc,
                         input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] mbv,
                         input logic [3:0] byp, input logic [1:0] wc, input logic mc);
        IR = ir; E_Control = ec; npc_in = npc; VSR1 = v1; VSR2 = v2; Mem_Bypass_Val = mbv;
        {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2} = byp;
        W_Control_in = wc; Mem_Control_in = mc;
    endtask

    task automatic push(input logic [15:0] e_alu, input logic [15:0] e_pc,
                        input logic [15:0] e_md, input logic [2:0] e_nzp, input logic [2:0] e_dr);
        exp_t e;
        e.alu = e_alu; e.pc = e_pc; e.md = e_md; e.nzp = e_nzp; e.dr = e_dr;
        e.ir = IR; e.wc = W_Control_in; e.mc = Mem_Control_in;
        q.push_back(e);
        last = e;
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clock);
        #1;
        if (q.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = q.pop_front();
            chk_all(tag, e);
        end
    endtask

    initial begin
        exp_t zero;
        zero = '{alu: 16'h0, pc: 16'h0, md: 16'h0, ir: 16'h0, nzp: 3'b0, dr: 3'b0, wc: 2'b0, mc: 1'b0};
        reset = 1'b0;
        enable_execute = 1'b1;
        drive(16'h1261, 6'b000000, 16'h0, 16'h0005, 16'h0, 16'h0, 4'b0000, 2'b00, 1'b0);
        #1;
        chk_all("reset", zero);
        chk("reset.sr1", {13'b0, sr1}, 16'd1);
        chk("reset.sr2", {13'b0, sr2}, 16'd1);
        @(negedge clock);
        reset = 1'b1;

        drive(16'h1261, 6'b000000, 16'h0, 16'h0005, 16'h0000, 16'h0, 4'b0000, 2'b01, 1'b0);
        push(16'h0006, 16'h0266, 16'h0000, 3'b000, 3'b001);
        tick("add_imm");

        drive(16'h1261, 6'b000000, 16'h0, 16'hFFFF, 16'h0000, 16'h0, 4'b0000, 2'b10, 1'b1);
        push(16'h0000, 16'h0260, 16'h0000, 3'b000, 3'b001);
        tick("add_wrap");

        drive(16'h5242, 6'b011101, 16'h0, 16'hF0F0, 16'h0FF0, 16'h0, 4'b0000, 2'b11, 1'b0);
        #1 chk("and.sr2", {13'b0, sr2}, 16'd2);
        push(16'h00F0, 16'hF0F0, 16'h0FF0, 3'b000, 3'b001);
        tick("and_reg");

        drive(16'h927F, 6'b100000, 16'h0, 16'h00FF, 16'h0000, 16'h0, 4'b0000, 2'b00, 1'b1);
        push(16'hFF00, 16'h037E, 16'h0000, 3'b000, 3'b001);
        tick("not");

        drive(16'h1261, 6'b110000, 16'h0, 16'h0005, 16'h0000, 16'h0, 4'b0000, 2'b01, 1'b0);
        push(16'h0000, 16'h0266, 16'h0000, 3'b000, 3'b001);
        tick("alu_rsvd");

        drive(16'h0E05, 6'b000110, 16'h3001, 16'h0000, 16'h0000, 16'h0, 4'b0000, 2'b00, 1'b0);
        push(16'h3006, 16'h3006, 16'h0000, 3'b111, 3'b111);
        tick("br_fwd");

        drive(16'h0FFF, 6'b000110, 16'h3001, 16'h0000, 16'h0000, 16'h0, 4'b0000, 2'b00, 1'b0);
        push(16'h3000, 16'h3000, 16'h0000, 3'b111, 3'b111);
        tick("br_back");

        drive(16'hC1C0, 6'b001100, 16'h3001, 16'h5000, 16'h0000, 16'h0, 4'b0000, 2'b00, 1'b0);
        push(16'h5000, 16'h5000, 16'h0000, 3'b111, 3'b000);
        tick("jmp");

        drive(16'h1261, 6'b000000, 16'h0, 16'h0005, 16'h0000, 16'h0, 4'b0000, 2'b01, 1'b0);
        push(16'h0006, 16'h0266, 16'h0000, 3'b000, 3'b001);
        tick("add_seed");

        drive(16'h1261, 6'b000000, 16'h0, 16'h0005, 16'h0000, 16'h00FF, 4'b1100, 2'b01, 1'b0);
        push(16'h0007, 16'h0267, 16'h0000, 3'b000, 3'b001);
        tick("byp_both");

        drive(16'h1261, 6'b000000, 16'h0, 16'h0005, 16'h0000, 16'h00FF, 4'b0100, 2'b01, 1'b0);
        push(16'h0100, 16'h0360, 16'h0000, 3'b000, 3'b001);
        tick("byp_mem");

        drive(16'h7A42, 6'b001000, 16'h0, 16'h4000, 16'hBEEF, 16'h0, 4'b0000, 2'b00, 1'b1);
        #1 chk("str.sr2", {13'b0, sr2}, 16'd5);
        push(16'h4002, 16'h4002, 16'hBEEF, 3'b000, 3'b101);
        tick("str");

        drive(16'h7A42, 6'b001000, 16'h0, 16'h4000, 16'hBEEF, 16'h0, 4'b0010, 2'b00, 1'b1);
        push(16'h4002, 16'h4002, 16'h4002, 3'b000, 3'b101);
        tick("str_byp_alu");

        drive(16'h7A42, 6'b001000, 16'h0, 16'h4000, 16'hBEEF, 16'h1234, 4'b0001, 2'b10, 1'b0);
        push(16'h4002, 16'h4002, 16'h1234, 3'b000, 3'b101);
        tick("str_byp_mem");

        enable_execute = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(16'h1000 + 16'(i), 6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
            q.push_back(last);
            tick("hold");
        end
        enable_execute = 1'b1;

        drive(16'h1261, 6'b000000, 16'h0, 16'h0005, 16'h0000, 16'h0, 4'b0000, 2'b01, 1'b1);
        push(16'h0006, 16'h0266, 16'h0000, 3'b000, 3'b001);
        tick("pre_reset");
        #2 reset = 1'b0;
        #1 chk_all("mid_reset", zero);
        @(negedge clock);
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
